// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared constants and types for the ID-stage general-purpose register file.
//   DEFAULT_REG_WIDTH : default width of every register and data port
//   DEFAULT_ADDR_BITS : default register-index width
//   NUM_REGS          : register count derived from DEFAULT_ADDR_BITS
//   reg_idx_t         : register index at the default geometry
//   data_word_t       : data word at the default geometry
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int DEFAULT_REG_WIDTH = 16;
  localparam int DEFAULT_ADDR_BITS = 3;
  localparam int NUM_REGS          = 1 << DEFAULT_ADDR_BITS;

  typedef logic [DEFAULT_ADDR_BITS-1:0] reg_idx_t;
  typedef logic [DEFAULT_REG_WIDTH-1:0] data_word_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file: an address-indexed mux
// over the stored registers, with an optional same-cycle write-through bypass.
// When BypassEn is set and the write port targets the addressed register,
// the in-flight write data is returned instead of the stored contents.
//   i_regs     : stored register contents
//   i_addr     : register index to read
//   i_byp_en   : a write is being committed this cycle
//   i_byp_addr : index of that write
//   i_byp_data : data of that write
//   o_data     : read result
// -----------------------------------------------------------------------------
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int RegWidth = DEFAULT_REG_WIDTH,
  parameter int AddrBits = DEFAULT_ADDR_BITS,
  parameter int NumRegs  = 1 << AddrBits,
  parameter bit BypassEn = 1'b1
) (
  input  logic [RegWidth-1:0] i_regs [NumRegs],
  input  logic [AddrBits-1:0] i_addr,
  input  logic                i_byp_en,
  input  logic [AddrBits-1:0] i_byp_addr,
  input  logic [RegWidth-1:0] i_byp_data,
  output logic [RegWidth-1:0] o_data
);

  logic w_hit;

  assign w_hit = BypassEn && i_byp_en && (i_byp_addr == i_addr);

  // NOTE: o_data gets a value on every path through this block, so no latch
  // is inferred; the bypass simply overrides the default.
  always_comb begin
    o_data = i_regs[i_addr];
    if (w_hit) begin
      o_data = i_byp_data;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// General-purpose register file for the ID stage: 2^AddrBits registers of
// RegWidth bits, one synchronous write port (write-back), two combinational
// operand read ports with write-through bypass, and one combinational debug
// read port that shows stored contents only.
//   CLK       : clock, all state updates on the rising edge
//   RST       : synchronous active-high reset, clears every register
//   WriteEN   : write enable
//   WriteAddr : write index
//   WriteData : write data
//   ReadAddr1 / ReadData1 : operand read port 1 (bypassed)
//   ReadAddr2 / ReadData2 : operand read port 2 (bypassed)
//   inr / out_value       : debug read port (not bypassed)
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int RegWidth = DEFAULT_REG_WIDTH,
  parameter int AddrBits = DEFAULT_ADDR_BITS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WriteEN,
  input  logic [AddrBits-1:0] WriteAddr,
  input  logic [RegWidth-1:0] WriteData,
  input  logic [AddrBits-1:0] ReadAddr1,
  output logic [RegWidth-1:0] ReadData1,
  input  logic [AddrBits-1:0] ReadAddr2,
  output logic [RegWidth-1:0] ReadData2,
  input  logic [AddrBits-1:0] inr,
  output logic [RegWidth-1:0] out_value
);

  localparam int NumRegs = 1 << AddrBits;

  logic [RegWidth-1:0] r_regs [NumRegs];
  logic                w_commit;

  // A write only lands when reset is not asserted, so the bypass must
  // follow the same qualification or the read ports would show a value
  // that never reaches storage.
  assign w_commit = WriteEN && !RST;

  // NOTE: the whole array is cleared on reset because software relies on
  // every register reading zero afterwards; this rules out a RAM macro,
  // which is acceptable at this size.
  // NOTE: non-blocking assignments here so every read in the same cycle
  // sees the pre-edge contents regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WriteEN) begin
      r_regs[WriteAddr] <= WriteData;
    end
  end

  regfile_read_port #(
    .RegWidth (RegWidth),
    .AddrBits (AddrBits),
    .BypassEn (1'b1)
  ) u_read_port1 (
    .i_regs     (r_regs),
    .i_addr     (ReadAddr1),
    .i_byp_en   (w_commit),
    .i_byp_addr (WriteAddr),
    .i_byp_data (WriteData),
    .o_data     (ReadData1)
  );

  regfile_read_port #(
    .RegWidth (RegWidth),
    .AddrBits (AddrBits),
    .BypassEn (1'b1)
  ) u_read_port2 (
    .i_regs     (r_regs),
    .i_addr     (ReadAddr2),
    .i_byp_en   (w_commit),
    .i_byp_addr (WriteAddr),
    .i_byp_data (WriteData),
    .o_data     (ReadData2)
  );

  // The debug port observes stored state only, so its bypass is disabled.
  regfile_read_port #(
    .RegWidth (RegWidth),
    .AddrBits (AddrBits),
    .BypassEn (1'b0)
  ) u_debug_port (
    .i_regs     (r_regs),
    .i_addr     (inr),
    .i_byp_en   (1'b0),
    .i_byp_addr ('0),
    .i_byp_data ('0),
    .o_data     (out_value)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed self-checking bench for register_file. Expected port values are
// pushed to a scoreboard queue as each step is driven and popped when the
// outputs are sampled, a time unit after the inputs settle and away from the
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_register_file;
  import register_file_pkg::*;

  typedef struct {
    string      tag;
    data_word_t rd1;
    data_word_t rd2;
    data_word_t dbg;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WriteEN;
  reg_idx_t   WriteAddr;
  data_word_t WriteData;
  reg_idx_t   ReadAddr1;
  data_word_t ReadData1;
  reg_idx_t   ReadAddr2;
  data_word_t ReadData2;
  reg_idx_t   inr;
  data_word_t out_value;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  register_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .WriteEN   (WriteEN),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr1 (ReadAddr1),
    .ReadData1 (ReadData1),
    .ReadAddr2 (ReadAddr2),
    .ReadData2 (ReadData2),
    .inr       (inr),
    .out_value (out_value)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input data_word_t obs, input data_word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input data_word_t e1,
                            input data_word_t e2, input data_word_t ed);
    exp_t e;
    e.tag = tag;
    e.rd1 = e1;
    e.rd2 = e2;
    e.dbg = ed;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare all three read ports against it.
  task automatic sample();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".rd1"}, ReadData1, e.rd1);
      check({e.tag, ".rd2"}, ReadData2, e.rd2);
      check({e.tag, ".dbg"}, out_value, e.dbg);
    end
  endtask

  task automatic set_reads(input reg_idx_t a1, input reg_idx_t a2, input reg_idx_t ad);
    ReadAddr1 = a1;
    ReadAddr2 = a2;
    inr       = ad;
  endtask

  task automatic write(input reg_idx_t a, input data_word_t d);
    WriteEN   = 1'b1;
    WriteAddr = a;
    WriteData = d;
    tick();
    WriteEN   = 1'b0;
  endtask

  initial begin
    data_word_t v;
    data_word_t w;

    RST = 1'b1; WriteEN = 1'b0; WriteAddr = '0; WriteData = '0;
    set_reads(0, 0, 0);
    #1;
    tick();
    RST = 1'b0;

    // Reset state reads zero on every port.
    set_reads(0, 7, 3);
    expect_out("reset_state", 16'h0000, 16'h0000, 16'h0000);
    sample();

    // Write sequence, then read back with WriteEN low.
    write(3'd1, 16'd25);
    write(3'd2, 16'd99);
    write(3'd3, -16'sd40);
    set_reads(1, 2, 3);
    expect_out("write_seq", 16'd25, 16'd99, 16'hFFD8);
    sample();

    // Write disabled: R2 keeps 99 across several edges.
    WriteEN = 1'b0; WriteAddr = 3'd2; WriteData = 16'hFFFF;
    set_reads(2, 2, 2);
    expect_out("we_low_pre", 16'd99, 16'd99, 16'd99);
    sample();
    repeat (3) tick();
    expect_out("we_low_post", 16'd99, 16'd99, 16'd99);
    sample();

    // Bypass: R4 holds 7, write ABCD while all ports address 4.
    write(3'd4, 16'd7);
    WriteEN = 1'b1; WriteAddr = 3'd4; WriteData = 16'hABCD;
    set_reads(4, 4, 4);
    expect_out("bypass_pre", 16'hABCD, 16'hABCD, 16'd7);
    sample();
    tick();
    WriteEN = 1'b0;
    expect_out("bypass_post", 16'hABCD, 16'hABCD, 16'hABCD);
    sample();

    // Bypass only on the matching port.
    WriteEN = 1'b1; WriteAddr = 3'd1; WriteData = 16'h5A5A;
    set_reads(1, 2, 1);
    expect_out("bypass_one_port", 16'h5A5A, 16'd99, 16'd25);
    sample();
    WriteEN = 1'b0;
    expect_out("bypass_cancel", 16'd25, 16'd99, 16'd25);
    sample();

    // Synchronous reset: unchanged before the edge, zero after.
    RST = 1'b1;
    set_reads(1, 2, 3);
    expect_out("rst_pre_edge", 16'd25, 16'd99, 16'hFFD8);
    sample();
    tick();
    expect_out("rst_post_edge", 16'h0000, 16'h0000, 16'h0000);
    sample();
    RST = 1'b0;
    tick();
    set_reads(4, 1, 4);
    expect_out("rst_released", 16'h0000, 16'h0000, 16'h0000);
    sample();

    // Reset beats a simultaneous write, and suppresses the bypass.
    RST = 1'b1; WriteEN = 1'b1; WriteAddr = 3'd5; WriteData = 16'h1234;
    set_reads(5, 5, 5);
    expect_out("rst_vs_write_pre", 16'h0000, 16'h0000, 16'h0000);
    sample();
    tick();
    RST = 1'b0; WriteEN = 1'b0;
    expect_out("rst_vs_write_post", 16'h0000, 16'h0000, 16'h0000);
    sample();

    // Full sweep: reg[i] = i * 16'h1111, including R0 and R7.
    for (int i = 0; i < NUM_REGS; i++) begin
      v = data_word_t'(i) * 16'h1111;
      write(reg_idx_t'(i), v);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      v = data_word_t'(i) * 16'h1111;
      w = data_word_t'(NUM_REGS - 1 - i) * 16'h1111;
      set_reads(reg_idx_t'(i), reg_idx_t'(NUM_REGS - 1 - i), reg_idx_t'(i));
      expect_out($sformatf("sweep_%0d", i), v, w, v);
      sample();
    end

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
